// File: rtl/door_lock_pkg.sv
// Shared door-lock definitions: controller state encoding, timer widths, escalation cap.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package door_lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    // Seconds counter width; comfortably covers LOCK_SEC * 8 for realistic settings.
    localparam int SEC_W = 16;

    // Escalation level register width and its saturation value (max 8x lockout).
    localparam int ESC_W   = 2;
    localparam int ESC_MAX = 3;

endpackage

// File: rtl/sec_timer.sv
// Seconds timer: cycle prescaler wrapping at CLK_IN-1, seconds counter bumped on each wrap.
// Latency: clear takes effect on the next rising edge; tick is a combinational decode of the prescaler.
// Backpressure: none; free-running whenever clear is low.
module sec_timer #(
    parameter int CLK_IN = 500,
    parameter int SEC_W  = 16
) (
    input  logic             clk,
    input  logic             clear,
    output logic             tick,
    output logic [SEC_W-1:0] sec
);

    localparam int PW = (CLK_IN > 1) ? $clog2(CLK_IN) : 1;

    logic [PW-1:0] presc;

    // Last cycle of the current second.
    assign tick = (presc == PW'(CLK_IN - 1));

    // Prescaler and seconds counter; clear wins so every state entry starts at zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            presc <= '0;
            sec   <= '0;
        end else if (tick) begin
            presc <= '0;
            sec   <= sec + SEC_W'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/lockout_ctrl.sv
// Door lock controller: unlocks on a good passcode, locks out after MAX_FAIL consecutive bad ones.
// Latency: one cycle from attempt strobe to registered outputs; timed states last whole seconds.
// Backpressure: none; attempts arriving in UNLOCKED or LOCKOUT are dropped. Optional macro LOCKOUT_ESCALATE_EN doubles lockout per repeat (cap 8x).
module lockout_ctrl
    import door_lock_pkg::*;
#(
    parameter int CLK_IN   = 500,
    parameter int MAX_FAIL = 3,
    parameter int LOCK_SEC = 10,
    parameter int OPEN_SEC = 5
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_attempt_valid,
    input  logic       i_attempt_ok,
    output logic       o_unlock,
    output logic       o_lockout,
    output logic [3:0] o_fail_cnt
);

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        fail_nxt;
    logic              tmr_clear;
    logic              tmr_tick;
    logic [SEC_W-1:0]  tmr_sec;
    logic [SEC_W-1:0]  lock_sec;

    // Timer restarts on reset, on every state change, and idles cleared in IDLE.
    assign tmr_clear = i_reset || (state_nxt != state) || (state == ST_IDLE);

    sec_timer #(
        .CLK_IN (CLK_IN),
        .SEC_W  (SEC_W)
    ) u_timer (
        .clk   (i_clk),
        .clear (tmr_clear),
        .tick  (tmr_tick),
        .sec   (tmr_sec)
    );

`ifdef LOCKOUT_ESCALATE_EN
    // esc_lvl counts lockouts since the last unlock; esc_cur is the level applied to the running lockout.
    logic [ESC_W-1:0] esc_lvl;
    logic [ESC_W-1:0] esc_cur;

    assign lock_sec = SEC_W'(LOCK_SEC) << esc_cur;

    // Escalation tracking: capture level and bump (saturating) on lockout entry, clear on unlock entry.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            esc_lvl <= '0;
            esc_cur <= '0;
        end else if (state == ST_IDLE && state_nxt == ST_LOCKOUT) begin
            esc_cur <= esc_lvl;
            if (esc_lvl != ESC_W'(ESC_MAX)) begin
                esc_lvl <= esc_lvl + ESC_W'(1);
            end
        end else if (state == ST_IDLE && state_nxt == ST_UNLOCKED) begin
            esc_lvl <= '0;
            esc_cur <= '0;
        end
    end
`else
    assign lock_sec = SEC_W'(LOCK_SEC);
`endif

    // Next state and next failure count; timed states ignore attempts entirely.
    always_comb begin
        state_nxt = state;
        fail_nxt  = o_fail_cnt;
        case (state)
            ST_IDLE: begin
                if (i_attempt_valid) begin
                    if (i_attempt_ok) begin
                        state_nxt = ST_UNLOCKED;
                        fail_nxt  = 4'd0;
                    end else if (o_fail_cnt == 4'(MAX_FAIL - 1)) begin
                        state_nxt = ST_LOCKOUT;
                        fail_nxt  = 4'd0;
                    end else begin
                        fail_nxt  = o_fail_cnt + 4'd1;
                    end
                end
            end
            ST_UNLOCKED: begin
                if (tmr_tick && tmr_sec == SEC_W'(OPEN_SEC - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_tick && tmr_sec == lock_sec - SEC_W'(1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                fail_nxt  = 4'd0;
            end
        endcase
    end

    // State and registered outputs; reset overrides any pending transition.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            o_unlock   <= 1'b0;
            o_lockout  <= 1'b0;
            o_fail_cnt <= 4'd0;
        end else begin
            state      <= state_nxt;
            o_unlock   <= (state_nxt == ST_UNLOCKED);
            o_lockout  <= (state_nxt == ST_LOCKOUT);
            o_fail_cnt <= fail_nxt;
        end
    end

endmodule

// File: doc/lockout_ctrl.md
LOCKOUT_CTRL -- requirements
Module: lockout_ctrl

Interface
REQ-001 SHALL have parameter CLK_IN, default 500, meaning i_clk cycles per second.
REQ-002 SHALL have parameter MAX_FAIL, default 3, meaning consecutive wrong attempts that trigger lockout (legal range 1..15).
REQ-003 SHALL have parameter LOCK_SEC, default 10, meaning base lockout duration in seconds (>=1).
REQ-004 SHALL have parameter OPEN_SEC, default 5, meaning unlocked hold duration in seconds (>=1).
REQ-005 SHALL have port i_clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port i_attempt_valid  input  1  one-cycle strobe: a passcode attempt is complete.
REQ-008 SHALL have port i_attempt_ok  input  1  attempt matched; sampled only when i_attempt_valid=1.
REQ-009 SHALL have port o_unlock  output  1  door-release level, high during UNLOCKED.
REQ-010 SHALL have port o_lockout  output  1  high during LOCKOUT; drives the LED blinker i_en.
REQ-011 SHALL have port o_fail_cnt  output  4  current consecutive-failure count.

Function
REQ-012 SHALL implement states IDLE, UNLOCKED, LOCKOUT; all outputs registered.
REQ-013 IDLE, valid & ok: next cycle state=UNLOCKED, o_unlock=1, o_fail_cnt=0.
REQ-014 IDLE, valid & !ok, o_fail_cnt<MAX_FAIL-1: o_fail_cnt increments next cycle, state stays IDLE.
REQ-015 IDLE, valid & !ok, o_fail_cnt=MAX_FAIL-1: next cycle state=LOCKOUT, o_lockout=1, o_fail_cnt=0.
REQ-016 UNLOCKED SHALL last exactly OPEN_SEC*CLK_IN cycles, then return to IDLE with o_unlock=0.
REQ-017 LOCKOUT SHALL last exactly D*CLK_IN cycles (D per REQ-024/025), then return to IDLE with o_lockout=0.
REQ-018 i_attempt_valid SHALL be ignored in UNLOCKED and LOCKOUT, including on the exit cycle; no count change.
REQ-019 i_attempt_ok SHALL be don't-care when i_attempt_valid=0.
REQ-020 Timer (cycle prescaler + seconds counter) SHALL clear on every state entry; prescaler wraps at CLK_IN-1, seconds counter increments on wrap.
REQ-021 o_unlock and o_lockout SHALL never be high together.

Reset
REQ-022 i_reset=1 at a rising edge SHALL force state=IDLE, o_unlock=0, o_lockout=0, o_fail_cnt=0, timer=0, escalation level=0 on that edge.
REQ-023 Reset asserted mid-UNLOCKED or mid-LOCKOUT SHALL abort the period immediately; reset has priority over every other event.

Configuration
REQ-024 With LOCKOUT_ESCALATE_EN defined: D=LOCK_SEC*2^L, L = lockouts since the last successful unlock, saturating at 3 (max 8x); L increments on LOCKOUT entry, clears on UNLOCKED entry.
REQ-025 Without LOCKOUT_ESCALATE_EN: D=LOCK_SEC always; no escalation register synthesized.

Structure
REQ-026 State encodings and escalation cap (3) SHALL live in shared package door_lock_pkg.
REQ-027 The timer SHALL be a sub-module sec_timer (inputs clk, clear; params CLK_IN; outputs seconds count), reused by both timed states.

Verification (bench: CLK_IN=10, MAX_FAIL=3, LOCK_SEC=2, OPEN_SEC=1)
REQ-028 Correct attempt from IDLE -> o_unlock=1 next cycle, held exactly 10 cycles, then 0.
REQ-029 Two wrong then one correct -> o_fail_cnt 1,2,0; o_unlock=1; o_lockout stays 0.
REQ-030 Three wrong -> o_lockout=1 next cycle after third, held exactly 20 cycles; strobes (ok and !ok) during lockout leave o_fail_cnt=0 and do not extend it.
REQ-031 Reset pulse at cycle 5 of lockout -> o_lockout=0 on that edge; next wrong attempt gives o_fail_cnt=1.
REQ-032 LOCKOUT_ESCALATE_EN: four consecutive lockouts -> durations 20, 40, 80, 160 cycles; fifth 160; correct attempt then lockout -> 20.
REQ-033 Attempt strobe on the final lockout cycle -> ignored; IDLE entered with o_fail_cnt=0.
